// File: rtl/seq_mult_hs.sv
// seq_mult_hs: WIDTH x WIDTH sequential shift-add multiplier with valid/ready handshakes.
// The optional early-termination feature is enabled with `define SEQ_MULT_HS_EARLY_TERM_EN.
`default_nettype none

module seq_mult_hs #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q,  state_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic                 sgn_q,    sgn_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic                 last_bit;
  logic                 finish;
  logic [2*WIDTH-1:0]   acc_next;

  assign last_bit = (cnt_q == LAST_CNT);

  // In signed mode the top multiplier bit carries weight -2^(WIDTH-1), so it subtracts.
  always_comb begin
    acc_next = acc_q;
    if (mplier_q[0]) begin
      if (last_bit && sgn_q) begin
        acc_next = acc_q - mcand_q;
      end else begin
        acc_next = acc_q + mcand_q;
      end
    end
  end

`ifdef SEQ_MULT_HS_EARLY_TERM_EN
  assign finish = last_bit || (mplier_q[WIDTH-1:1] == '0);
`else
  assign finish = last_bit;
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sgn_d    = is_signed;
          mcand_d  = {{WIDTH{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
          mplier_d = multiplier;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (finish) begin
          result_d = acc_next;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult_hs.sv
// tb_seq_mult_hs: directed and randomized self-checking bench for seq_mult_hs (WIDTH=8).
// Honours SEQ_MULT_HS_EARLY_TERM_EN for expected latencies.
`default_nettype none

module tb_seq_mult_hs;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           is_signed;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  seq_mult_hs #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference product computed with plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint sa, sb, p;
    logic [63:0] pv;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[W-1]) sa = sa - (longint'(1) << W);
    if (s && b[W-1]) sb = sb - (longint'(1) << W);
    p  = sa * sb;
    pv = p;
    return pv[2*W-1:0];
  endfunction

  // Number of RUN cycles a multiplier value takes.
  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SEQ_MULT_HS_EARLY_TERM_EN
    int n;
    n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction

  // Transaction-level model: 0 = idle, 1 = computing (countdown), 2 = result offered.
  int             m_phase;
  int             m_left;
  logic [2*W-1:0] m_prod;
  logic [2*W-1:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_prod  <= '0;
      m_res   <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_prod  <= ref_mul(multiplicand, multiplier, is_signed);
          m_left  <= exp_lat(multiplier);
          m_phase <= 1;
        end
        1: begin
          if (m_left == 1) begin
            m_phase <= 2;
            m_res   <= m_prod;
          end
          m_left <= m_left - 1;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cycle {in_ready,out_valid,busy,result}",
            {45'd0, in_ready, out_valid, busy, result},
            {45'd0, (m_phase == 0), (m_phase == 2), (m_phase != 0), m_res});
    end
  end

  task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("accept timeout", 64'd0, 64'd1);
    in_valid     = 1'b1;
    multiplicand = a;
    multiplier   = b;
    is_signed    = s;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    is_signed    = 1'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("out_valid timeout", 64'd0, 64'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                     input logic [2*W-1:0] exp_res, input int lat_exp, input string name);
    int lat;
    do_accept(a, b, s);
    wait_out(lat);
    check({name, " latency"}, 64'(lat), 64'(lat_exp));
    check({name, " result"}, 64'(result), 64'(exp_res));
    handshake();
    check({name, " out_valid drop"}, 64'(out_valid), 64'd0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return W'(0);
      1: return W'(1);
      2: return W'(1) << (W - 1);
      3: return '1;
      4: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  localparam bit ET =
`ifdef SEQ_MULT_HS_EARLY_TERM_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    int lat;
    rst_n        = 1'b1;
    in_valid     = 1'b0;
    is_signed    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    out_ready    = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset result", 64'(result), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle in_ready", 64'(in_ready), 64'd1);
    check("idle result", 64'(result), 64'h0000);

    txn(8'h80, 8'h80, 1'b1, 16'h4000, 8, "s 0x80*0x80");
    txn(8'h05, 8'hFD, 1'b1, 16'hFFF1, 8, "s 5*-3");
    txn(8'hFF, 8'hFF, 1'b0, 16'hFE01, 8, "u 0xFF*0xFF");
    txn(8'hFF, 8'h80, 1'b0, 16'h7F80, 8, "u 0xFF*0x80");
    txn(8'h9C, 8'h01, 1'b0, 16'h009C, ET ? 1 : 8, "u 0x9C*0x01");
    txn(8'h9C, 8'hFF, 1'b1, 16'h0064, 8, "s 0x9C*0xFF");
    txn(8'h11, 8'h04, 1'b0, 16'h0044, ET ? 3 : 8, "u 0x11*0x04");
    txn(8'hAB, 8'h00, 1'b1, 16'h0000, ET ? 1 : 8, "s 0xAB*0");

    // Backpressure: result must hold and new operands must be ignored while DONE.
    do_accept(8'h12, 8'h34, 1'b0);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid     = 1'b1;
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
      is_signed    = 1'($urandom);
      @(posedge clk);
      #1;
      check("bp result", 64'(result), 64'h03A8);
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp out_valid", 64'(out_valid), 64'd1);
    end
    multiplicand = 8'h03;
    multiplier   = 8'h07;
    is_signed    = 1'b0;
    out_ready    = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp back to idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(lat);
    check("bp next latency", 64'(lat), ET ? 64'd3 : 64'd8);
    check("bp next result", 64'(result), 64'h0015);
    handshake();

    // Asynchronous reset in the middle of RUN.
    do_accept(8'h55, 8'hF7, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    check("pre-reset busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async rst in_ready", 64'(in_ready), 64'd1);
    check("async rst out_valid", 64'(out_valid), 64'd0);
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst result", 64'(result), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    txn(8'h03, 8'h07, 1'b0, 16'h0015, ET ? 3 : 8, "post-reset 3*7");

    // Randomized traffic; the compare process checks every cycle against the model.
    for (int t = 0; t < 2000; t++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      do_accept(pick_operand(), pick_operand(), 1'($urandom));
      out_ready = 1'($urandom);
      wait_out(lat);
      out_ready = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      handshake();
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_mult_hs.md
Name: seq_mult_hs

Overview:
- Parametrised sequential shift-add multiplier for the NN datapath. It is the successor to the fixed 8-bit signed multiplier.
- Supports a configurable operand width and a per-transaction signed/unsigned mode.
- Operands are captured at acceptance, and input and output use valid/ready handshakes.
- Processes one multiplier bit per cycle and sits between the weight/activation fetch stage and the accumulator.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); result is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and mode presented
- in_ready  output  1  block can accept operands
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
- multiplicand  input  WIDTH  operand A
- multiplier  input  WIDTH  operand B
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  2*WIDTH  product A*B
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0, async, no clock needed):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - result=0, accumulator=0, counter=0.
  - Reset asserted mid-RUN or in DONE aborts the operation; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a rising edge (acceptance):
    - Capture is_signed.
    - Capture the multiplicand into a 2*WIDTH shift register, sign-extended if is_signed else zero-extended.
    - Capture the multiplier into a WIDTH shift register.
    - accumulator=0, counter=0, next state RUN.
- RUN (one bit per cycle, in_ready=0):
  - If multiplier LSB=1:
    - counter<WIDTH-1, or is_signed=0: accumulator += multiplicand_reg.
    - counter==WIDTH-1 and is_signed=1: accumulator -= multiplicand_reg (sign-bit weight -2^(WIDTH-1)).
  - Then shift multiplicand_reg left by 1, shift multiplier_reg right by 1, counter++.
  - When counter==WIDTH-1 is processed, move to DONE and load result from the final accumulator value.
- DONE:
  - out_valid=1 and result stable until handshake.
  - On out_valid&&out_ready, go to IDLE; out_valid deasserts next cycle.
  - result holds its last value after the handshake.
- Latency (no early termination):
  - Acceptance at edge k gives out_valid=1 after edge k+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles with out_ready tied high.
- Arithmetic:
  - Accumulator is 2*WIDTH bits and wraps modulo 2^(2*WIDTH).
  - The exact product always fits, including the signed (-2^(WIDTH-1))^2 case.
- in_valid and operand changes during RUN/DONE are ignored; captured values are used.
- out_ready during IDLE/RUN is ignored.
- in_valid held high while in DONE is accepted only after returning to IDLE.

Optional Feature:
- Macro: SEQ_MULT_HS_EARLY_TERM_EN.
- Defined:
  - In RUN, after processing the current bit, if all remaining unprocessed multiplier_reg bits are zero, go directly to DONE.
  - Multiplier 0 or 1 gives out_valid after edge k+1.
  - Multiplier 0x04 gives k+3.
  - Signed negative multipliers always run full WIDTH cycles, because the sign bit is set.
  - result is bit-identical to the full-latency path.
- Undefined: latency is always exactly WIDTH RUN cycles regardless of operand values.

Test Plan:
- Reset then idle, no stimulus -> in_ready=1, out_valid=0, busy=0, result=0x0000.
- WIDTH=8, is_signed=1:
  - A=0x80, B=0x80 -> result=0x4000, out_valid after edge k+8.
  - A=0x05, B=0xFD (5*-3) -> result=0xFFF1.
- WIDTH=8, is_signed=0: A=0xFF, B=0xFF -> result=0xFE01; A=0xFF, B=0x80 -> 0x7F80.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while changing inputs with in_valid=1 -> result constant, in_ready=0.
  - Release out_ready -> IDLE, then the next operand pair is accepted.
- Async reset mid-RUN: assert rst_n=0 at RUN cycle 3 between edges -> outputs clear immediately; after release, a new pair A=0x03, B=0x07 gives 0x0015.
- With SEQ_MULT_HS_EARLY_TERM_EN:
  - Unsigned A=0x9C, B=0x01 -> result=0x009C at k+1.
  - Signed A=0x9C, B=0xFF -> result=0x0064 at k+8.
  - Random 10k pairs at WIDTH=8 and WIDTH=16 match the reference model in both modes.
